// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: 2-flop line synchronizer, mid-bit start qualification,
// centre sampling of each data bit, registered valid/framing-error strobes.
// Latency: strobes appear one cycle after the stop-bit centre sample; no backpressure
// (the byte is held only until the next good byte, so a missed o_valid loses it).
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   i_rx_bit     asynchronous serial line, idles high
//   o_data_byte  last good byte, held until the next good byte
//   o_valid      one-cycle pulse when o_data_byte updates
//   o_frame_err  one-cycle pulse when the stop bit samples low
//   rx_busy      high from start detect until return to IDLE
module uart_rx #(
  parameter int CLKS_PER_BITS = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx_bit,
  output logic [7:0] o_data_byte,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       rx_busy
);

  localparam logic [13:0] HALF_BIT = 14'((CLKS_PER_BITS - 1) / 2);
  localparam logic [13:0] BIT_LAST = 14'(CLKS_PER_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state_q;
  logic        rx_meta_q;
  logic        rx_s_q;
  logic [13:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;

  logic [13:0] cnt_d;
  logic [2:0]  idx_d;

  assign cnt_d = cnt_q + 14'd1;
  assign idx_d = idx_q + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Sync flops reset to the idle level so a low line after reset is seen
      // as a fresh falling level rather than a stale one.
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= 14'd0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      o_data_byte <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      rx_meta_q   <= i_rx_bit;
      rx_s_q      <= rx_meta_q;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;

      case (state_q)
        S_IDLE: begin
          cnt_q <= 14'd0;
          idx_q <= 3'd0;
          if (!rx_s_q) begin
            state_q <= S_START;
            rx_busy <= 1'b1;
          end
        end

        S_START: begin
          // Half a bit in: still low means a real start bit, otherwise a glitch.
          if (cnt_q == HALF_BIT) begin
            cnt_q <= 14'd0;
            if (!rx_s_q) begin
              state_q <= S_DATA;
            end else begin
              state_q <= S_IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_DATA: begin
          // Counting from the start-bit centre, a full bit lands on each data centre.
          if (cnt_q == BIT_LAST) begin
            cnt_q          <= 14'd0;
            shift_q[idx_q] <= rx_s_q;
            idx_q          <= idx_d;
            if (idx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_STOP: begin
          // IDLE is re-entered at mid-stop-bit, leaving half a bit of margin
          // for a back-to-back start edge.
          if (cnt_q == BIT_LAST) begin
            cnt_q <= 14'd0;
            if (rx_s_q) begin
              o_data_byte <= shift_q;
              o_valid     <= 1'b1;
              state_q     <= S_IDLE;
              rx_busy     <= 1'b0;
            end else begin
              o_frame_err <= 1'b1;
              state_q     <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_BREAK: begin
          // A held-low line must go high before a new start can be detected.
          if (rx_s_q) begin
            state_q <= S_IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver, 8N1, LSB first, the receive-side counterpart to the team's byte-wide UART transmitter. It synchronizes the asynchronous serial line into `clk` and qualifies the start bit at mid-bit. Each bit is sampled at its centre, and each received byte is presented with a one-cycle valid strobe. A framing-error strobe flags a bad stop bit. It sits between the board RX pin and the APB-side register logic, with the default divider set for 100 MHz / 115200 baud.

## Interface
- `CLKS_PER_BITS`, 868: clocks per bit (100 MHz / 115200). Legal range 4..16383; the counter is 14 bits wide.
- `HALF_BIT`: derived, not overridable. Equals (`CLKS_PER_BITS` - 1) / 2, integer division (433 at default).
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_rx_bit`  in  1  asynchronous serial line; idles high.
- `o_data_byte`  out  8  last good byte; held until the next good byte.
- `o_valid`  out  1  one-cycle pulse when `o_data_byte` is updated.
- `o_frame_err`  out  1  one-cycle pulse when the stop bit samples 0.
- `rx_busy`  out  1  high from start detect until return to IDLE.

## Operation
- **Synchronizer**
  - `i_rx_bit` passes through 2 flops, both reset to 1, producing `rx_s`.
  - All decisions use `rx_s` only.
- **Bit counter**
  - `cnt` increments each cycle while below its target.
  - At the target, the state's action fires and `cnt` clears to 0.
- **State machine**
  - IDLE: `cnt`=0 and index=0. If `rx_s`=0, go to START and set `rx_busy`=1.
  - START: at `cnt`==HALF_BIT, sample `rx_s`.
    - If 0: go to DATA.
    - If 1: treat as a glitch and return to IDLE, with no output pulse.
  - DATA: at `cnt`==`CLKS_PER_BITS`-1, write `rx_s` into `shift[index]` and increment index.
    - After index 7 is written, go to STOP.
  - STOP: at `cnt`==`CLKS_PER_BITS`-1, sample `rx_s`.
    - If 1: load `o_data_byte` from `shift`, pulse `o_valid`, go to IDLE.
    - If 0: pulse `o_frame_err`, leave `o_data_byte` unchanged, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. A held-low line (break) must not retrigger reception.
- **`rx_busy`**
  - Clears on the same edge that enters IDLE.
  - The glitch path also clears it.
- **Reset**
  - Values: `o_data_byte`=0x00, `o_valid`=0, `o_frame_err`=0, `rx_busy`=0, state=IDLE, `cnt`=0, index=0, `shift`=0, sync flops=1.
  - Reset asserted mid-byte abandons the byte with no pulse.
  - After reset, reception restarts only on a fresh low level seen on `rx_s`.
- **Pulse exclusivity**: `o_valid` and `o_frame_err` are never high in the same cycle.

## Timing
- **Reference edge t0**: the first edge at which IDLE sees `rx_s`=0. This is the 3rd rising edge after the line falls, give or take 1 for asynchronous phase.
- **Sample edges**
  - Start check: t0 + 1 + HALF_BIT.
  - Data bit i (i = 0..7): t0 + 1 + HALF_BIT + (i+1)·`CLKS_PER_BITS`.
  - Stop bit: t0 + 1 + HALF_BIT + 9·`CLKS_PER_BITS`.
- **Outputs**: `o_valid` / `o_frame_err` are registered at the stop-sample edge. They are high for exactly the following cycle.
- **Back-to-back bytes**: IDLE is re-entered at mid-stop-bit, about HALF_BIT cycles before the next start edge can arrive. Back-to-back frames with zero idle time must therefore be received without loss.
- **Inter-byte gap**: no minimum.
- **Flow control**: none. A consumer that misses the `o_valid` pulse loses the byte, since `o_data_byte` stays valid only until the next good byte.
- **Baud tolerance**: centre sampling tolerates ±4% combined baud error.

## Test plan
Bench uses `CLKS_PER_BITS`=16 (HALF_BIT=7); the driver holds each bit for 16 clocks.
- **Reset defaults**: hold `rst` 5 cycles with the line high → all outputs at their reset values; no pulses for 200 idle cycles.
- **Single byte**: frame 0xA5 → `o_valid` high exactly 1 cycle at t0+1+7+144+1; `o_data_byte`=0xA5; `o_frame_err`=0; `rx_busy` low afterwards.
- **Back-to-back bytes**: 0x00, 0xFF, 0x81 with zero idle → three `o_valid` pulses 160 cycles apart; data in order 0x00, 0xFF, 0x81.
- **Glitch rejection**: line low for 4 cycles, then high → no pulse; `rx_busy` rises, then returns to 0 at t0+8.
- **Framing error and break**: 0x3C with stop bit 0, line held low 3 more bit times, then 0x5A → one `o_frame_err` pulse with `o_data_byte` unchanged; no reception during the low hold; then 0x5A received with `o_valid`.
- **Reset mid-byte**: assert `rst` during data bit 3 of 0xC3 → no pulse; outputs at reset values; next frame 0x96 is received correctly.
